// File: rtl/decode_stage.sv
// RiSC-16 instruction-decode / operand-read stage: decodes the IF/ID word, applies
// EX/MEM/WB bypassing, detects load-use hazards and registers the ID/EX bundle.
module decode_stage #(
    parameter int unsigned p_WORD_LEN     = 16,
    parameter int unsigned p_REG_ADDR_LEN = 3
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_valid,
    input  logic [p_WORD_LEN-1:0]     i_instr,
    input  logic [p_WORD_LEN-1:0]     i_pc,
    output logic                      o_stall,
    input  logic                      i_flush,
    input  logic                      i_hold,
    output logic [p_REG_ADDR_LEN-1:0] o_rf_src1,
    output logic [p_REG_ADDR_LEN-1:0] o_rf_src2,
    input  logic [p_WORD_LEN-1:0]     i_rf_src1_data,
    input  logic [p_WORD_LEN-1:0]     i_rf_src2_data,
    input  logic                      i_ex_valid,
    input  logic                      i_ex_wr_en,
    input  logic                      i_ex_is_load,
    input  logic [p_REG_ADDR_LEN-1:0] i_ex_tgt,
    input  logic [p_WORD_LEN-1:0]     i_ex_data,
    input  logic                      i_mem_wr_en,
    input  logic [p_REG_ADDR_LEN-1:0] i_mem_tgt,
    input  logic [p_WORD_LEN-1:0]     i_mem_data,
    input  logic                      i_wb_wr_en,
    input  logic [p_REG_ADDR_LEN-1:0] i_wb_tgt,
    input  logic [p_WORD_LEN-1:0]     i_wb_data,
    output logic                      o_valid,
    output logic [2:0]                o_opcode,
    output logic [p_REG_ADDR_LEN-1:0] o_tgt,
    output logic                      o_wr_en,
    output logic                      o_is_load,
    output logic [p_WORD_LEN-1:0]     o_op1,
    output logic [p_WORD_LEN-1:0]     o_op2,
    output logic [p_WORD_LEN-1:0]     o_imm,
    output logic [p_WORD_LEN-1:0]     o_pc
);

    localparam int unsigned OP_W   = 3;
    localparam int unsigned SIMM_W = 7;
    localparam int unsigned UIMM_W = 10;
    localparam int unsigned LUI_SH = 6;

    typedef enum logic [OP_W-1:0] {
        OP_ADD  = 3'd0,
        OP_ADDI = 3'd1,
        OP_NAND = 3'd2,
        OP_LUI  = 3'd3,
        OP_SW   = 3'd4,
        OP_LW   = 3'd5,
        OP_BEQ  = 3'd6,
        OP_JALR = 3'd7
    } opcode_e;

    typedef struct packed {
        logic                      valid;
        logic [OP_W-1:0]           opcode;
        logic [p_REG_ADDR_LEN-1:0] tgt;
        logic                      wr_en;
        logic                      is_load;
        logic [p_WORD_LEN-1:0]     op1;
        logic [p_WORD_LEN-1:0]     op2;
        logic [p_WORD_LEN-1:0]     imm;
        logic [p_WORD_LEN-1:0]     pc;
    } id_ex_t;

    opcode_e                   opcode;
    logic [p_REG_ADDR_LEN-1:0] ra, rb, rc;
    logic [p_REG_ADDR_LEN-1:0] src1, src2, tgt;
    logic                      src2_used, no_tgt, wr_en, hazard;
    logic [p_WORD_LEN-1:0]     imm, op1_fwd, op2_fwd;
    logic                      ex_fwd_en;
    id_ex_t                    id_ex_d, id_ex_q;

    // Field extraction and source/target/immediate decode
    always_comb begin
        opcode    = opcode_e'(i_instr[15:13]);
        ra        = p_REG_ADDR_LEN'(i_instr[12:10]);
        rb        = p_REG_ADDR_LEN'(i_instr[9:7]);
        rc        = p_REG_ADDR_LEN'(i_instr[2:0]);
        src1      = rb;
        src2      = '0;
        src2_used = 1'b0;
        case (opcode)
            OP_ADD, OP_NAND: begin
                src2      = rc;
                src2_used = 1'b1;
            end
            OP_SW, OP_BEQ: begin
                src2      = ra;
                src2_used = 1'b1;
            end
            default: ;
        endcase
        no_tgt = (opcode == OP_SW) || (opcode == OP_BEQ);
        tgt    = no_tgt ? '0 : ra;
        wr_en  = !no_tgt && (ra != '0);
        case (opcode)
            OP_LUI:  imm = p_WORD_LEN'({i_instr[UIMM_W-1:0], LUI_SH'(0)});
            OP_JALR: imm = '0;
            default: imm = {{(p_WORD_LEN-SIMM_W){i_instr[SIMM_W-1]}}, i_instr[SIMM_W-1:0]};
        endcase
    end

    // Bypass: r0 reads zero; youngest producer wins; loads in EX cannot forward
    function automatic logic [p_WORD_LEN-1:0] fwd(
        input logic [p_REG_ADDR_LEN-1:0] src,
        input logic [p_WORD_LEN-1:0]     rf_data,
        input logic                      ex_en,
        input logic [p_REG_ADDR_LEN-1:0] ex_tgt,
        input logic [p_WORD_LEN-1:0]     ex_data,
        input logic                      mem_en,
        input logic [p_REG_ADDR_LEN-1:0] mem_tgt,
        input logic [p_WORD_LEN-1:0]     mem_data,
        input logic                      wb_en,
        input logic [p_REG_ADDR_LEN-1:0] wb_tgt,
        input logic [p_WORD_LEN-1:0]     wb_data
    );
        if (src == '0)                      return '0;
        else if (ex_en && ex_tgt == src)    return ex_data;
        else if (mem_en && mem_tgt == src)  return mem_data;
        else if (wb_en && wb_tgt == src)    return wb_data;
        else                                return rf_data;
    endfunction

    assign ex_fwd_en = i_ex_valid & i_ex_wr_en & ~i_ex_is_load;
    assign op1_fwd   = fwd(src1, i_rf_src1_data, ex_fwd_en, i_ex_tgt, i_ex_data,
                           i_mem_wr_en, i_mem_tgt, i_mem_data, i_wb_wr_en, i_wb_tgt, i_wb_data);
    assign op2_fwd   = fwd(src2, i_rf_src2_data, ex_fwd_en, i_ex_tgt, i_ex_data,
                           i_mem_wr_en, i_mem_tgt, i_mem_data, i_wb_wr_en, i_wb_tgt, i_wb_data);

    assign hazard = i_valid & i_ex_valid & i_ex_is_load & (i_ex_tgt != '0) &
                    ((i_ex_tgt == src1) | (src2_used & (i_ex_tgt == src2)));

    assign o_stall   = ~i_flush & (i_hold | hazard);
    assign o_rf_src1 = src1;
    assign o_rf_src2 = src2;

    // ID/EX next state: flush > hold > load-use bubble > capture
    always_comb begin
        id_ex_d = id_ex_q;
        if (i_flush) begin
            id_ex_d.valid   = 1'b0;
            id_ex_d.wr_en   = 1'b0;
            id_ex_d.is_load = 1'b0;
        end else if (i_hold) begin
            id_ex_d = id_ex_q;
        end else if (hazard) begin
            id_ex_d.valid   = 1'b0;
            id_ex_d.wr_en   = 1'b0;
            id_ex_d.is_load = 1'b0;
        end else begin
            id_ex_d.valid   = i_valid;
            id_ex_d.opcode  = OP_W'(opcode);
            id_ex_d.tgt     = tgt;
            id_ex_d.wr_en   = i_valid & wr_en;
            id_ex_d.is_load = i_valid & (opcode == OP_LW);
            id_ex_d.op1     = op1_fwd;
            id_ex_d.op2     = op2_fwd;
            id_ex_d.imm     = imm;
            id_ex_d.pc      = i_pc;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) id_ex_q <= '0;
        else          id_ex_q <= id_ex_d;
    end

    assign o_valid   = id_ex_q.valid;
    assign o_opcode  = id_ex_q.opcode;
    assign o_tgt     = id_ex_q.tgt;
    assign o_wr_en   = id_ex_q.wr_en;
    assign o_is_load = id_ex_q.is_load;
    assign o_op1     = id_ex_q.op1;
    assign o_op2     = id_ex_q.op2;
    assign o_imm     = id_ex_q.imm;
    assign o_pc      = id_ex_q.pc;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios plus randomized
// traffic against a rule-level reference model.
module tb_decode_stage;

    logic        i_clk, i_rst_n, i_valid, i_flush, i_hold;
    logic [15:0] i_instr, i_pc, i_rf_src1_data, i_rf_src2_data;
    logic        o_stall;
    logic [2:0]  o_rf_src1, o_rf_src2;
    logic        i_ex_valid, i_ex_wr_en, i_ex_is_load, i_mem_wr_en, i_wb_wr_en;
    logic [2:0]  i_ex_tgt, i_mem_tgt, i_wb_tgt;
    logic [15:0] i_ex_data, i_mem_data, i_wb_data;
    logic        o_valid, o_wr_en, o_is_load;
    logic [2:0]  o_opcode, o_tgt;
    logic [15:0] o_op1, o_op2, o_imm, o_pc;

    int n_tests = 0;
    int n_fail  = 0;

    decode_stage dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .i_instr(i_instr), .i_pc(i_pc),
        .o_stall(o_stall), .i_flush(i_flush), .i_hold(i_hold),
        .o_rf_src1(o_rf_src1), .o_rf_src2(o_rf_src2),
        .i_rf_src1_data(i_rf_src1_data), .i_rf_src2_data(i_rf_src2_data),
        .i_ex_valid(i_ex_valid), .i_ex_wr_en(i_ex_wr_en), .i_ex_is_load(i_ex_is_load),
        .i_ex_tgt(i_ex_tgt), .i_ex_data(i_ex_data),
        .i_mem_wr_en(i_mem_wr_en), .i_mem_tgt(i_mem_tgt), .i_mem_data(i_mem_data),
        .i_wb_wr_en(i_wb_wr_en), .i_wb_tgt(i_wb_tgt), .i_wb_data(i_wb_data),
        .o_valid(o_valid), .o_opcode(o_opcode), .o_tgt(o_tgt), .o_wr_en(o_wr_en),
        .o_is_load(o_is_load), .o_op1(o_op1), .o_op2(o_op2), .o_imm(o_imm), .o_pc(o_pc)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic        v;
        logic [2:0]  op;
        logic [2:0]  tgt;
        logic        we;
        logic        ld;
        logic [15:0] op1, op2, imm, pc;
    } bundle_t;

    // ---------------- reference model (spec rules) ----------------
    function automatic logic [15:0] enc_rrr(input int op, input int a, input int b, input int c);
        return {3'(op), 3'(a), 3'(b), 4'b0, 3'(c)};
    endfunction
    function automatic logic [15:0] enc_rri(input int op, input int a, input int b, input int imm);
        return {3'(op), 3'(a), 3'(b), 7'(imm)};
    endfunction
    function automatic logic [15:0] enc_ri(input int op, input int a, input int imm);
        return {3'(op), 3'(a), 10'(imm)};
    endfunction

    function automatic int m_op();  return int'(i_instr[15:13]); endfunction
    function automatic bit m_no_tgt(); return (m_op() == 4) || (m_op() == 6); endfunction
    function automatic bit m_src2_used(); return m_op() inside {0, 2, 4, 6}; endfunction
    function automatic logic [2:0] m_src1(); return i_instr[9:7]; endfunction
    function automatic logic [2:0] m_src2();
        if (m_op() == 0 || m_op() == 2) return i_instr[2:0];
        if (m_op() == 4 || m_op() == 6) return i_instr[12:10];
        return 3'd0;
    endfunction

    function automatic logic [15:0] m_imm();
        int s;
        if (m_op() == 3) return 16'(int'(i_instr[9:0]) * 64);
        if (m_op() == 7) return 16'd0;
        s = int'(i_instr[6:0]);
        if (s >= 64) s = s - 128;
        return 16'(s);
    endfunction

    function automatic logic [15:0] m_fwd(input logic [2:0] src, input logic [15:0] rf);
        if (src == 3'd0) return 16'd0;
        if (i_ex_valid && i_ex_wr_en && !i_ex_is_load && i_ex_tgt == src) return i_ex_data;
        if (i_mem_wr_en && i_mem_tgt == src) return i_mem_data;
        if (i_wb_wr_en && i_wb_tgt == src) return i_wb_data;
        return rf;
    endfunction

    function automatic bit m_hazard();
        if (!(i_valid && i_ex_valid && i_ex_is_load) || i_ex_tgt == 3'd0) return 1'b0;
        return (i_ex_tgt == m_src1()) || (m_src2_used() && i_ex_tgt == m_src2());
    endfunction

    function automatic bundle_t m_capture();
        bundle_t b;
        b.v   = i_valid;
        b.op  = 3'(m_op());
        b.tgt = m_no_tgt() ? 3'd0 : i_instr[12:10];
        b.we  = i_valid && !m_no_tgt() && (i_instr[12:10] != 3'd0);
        b.ld  = i_valid && (m_op() == 5);
        b.op1 = m_fwd(m_src1(), i_rf_src1_data);
        b.op2 = m_fwd(m_src2(), i_rf_src2_data);
        b.imm = m_imm();
        b.pc  = i_pc;
        return b;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic set_idle();
        i_valid = 0; i_instr = '0; i_pc = '0; i_flush = 0; i_hold = 0;
        i_rf_src1_data = '0; i_rf_src2_data = '0;
        i_ex_valid = 0; i_ex_wr_en = 0; i_ex_is_load = 0; i_ex_tgt = '0; i_ex_data = '0;
        i_mem_wr_en = 0; i_mem_tgt = '0; i_mem_data = '0;
        i_wb_wr_en = 0; i_wb_tgt = '0; i_wb_data = '0;
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [75:0] all_out;
        i_rst_n = 0;
        set_idle();
        i_valid = 1; i_instr = enc_rrr(0, 1, 2, 3); i_rf_src1_data = 16'h1234;
        repeat (2) @(posedge i_clk);
        #1;
        all_out = {o_valid, o_opcode, o_tgt, o_wr_en, o_is_load, o_op1, o_op2, o_imm, o_pc};
        n_tests++;
        if (all_out !== '0) begin
            n_fail++; $display("FAIL reset_outputs: got %h expected 0", all_out);
        end
        @(negedge i_clk);
        i_rst_n = 1;
        set_idle();
        step();
    endtask

    task automatic test_ex_bypass();
        i_valid = 1; i_instr = enc_rrr(0, 1, 2, 3); i_pc = 16'h0010;
        step();
        i_instr = enc_rrr(0, 4, 1, 1); i_pc = 16'h0011;
        i_rf_src1_data = 16'hDEAD; i_rf_src2_data = 16'hBEEF;
        i_ex_valid = 1; i_ex_wr_en = 1; i_ex_is_load = 0; i_ex_tgt = 3'd1; i_ex_data = 16'h0005;
        #2;
        n_tests++;
        if ({o_rf_src1, o_rf_src2} !== {3'd1, 3'd1}) begin
            n_fail++; $display("FAIL ex_bypass_srcs: got %h/%h expected 1/1", o_rf_src1, o_rf_src2);
        end
        step();
        n_tests++;
        if ({o_valid, o_op1, o_op2, o_tgt, o_wr_en, o_pc} !== {1'b1, 16'h0005, 16'h0005, 3'd4, 1'b1, 16'h0011}) begin
            n_fail++;
            $display("FAIL ex_bypass: got v=%b op1=%h op2=%h tgt=%0d we=%b pc=%h expected v=1 op1=0005 op2=0005 tgt=4 we=1 pc=0011",
                     o_valid, o_op1, o_op2, o_tgt, o_wr_en, o_pc);
        end
        set_idle();
    endtask

    task automatic test_load_use();
        i_valid = 1; i_instr = enc_rri(1, 3, 2, -1);
        i_ex_valid = 1; i_ex_wr_en = 1; i_ex_is_load = 1; i_ex_tgt = 3'd2; i_ex_data = 16'hDEAD;
        i_rf_src1_data = 16'h9999;
        #2;
        n_tests++;
        if (o_stall !== 1'b1) begin n_fail++; $display("FAIL load_use_stall: got %b expected 1", o_stall); end
        step();
        n_tests++;
        if ({o_valid, o_wr_en, o_is_load} !== 3'b000) begin
            n_fail++; $display("FAIL load_use_bubble: got v/we/ld=%b expected 000", {o_valid, o_wr_en, o_is_load});
        end
        i_ex_valid = 0; i_ex_is_load = 0;
        i_mem_wr_en = 1; i_mem_tgt = 3'd2; i_mem_data = 16'h1234;
        #2;
        n_tests++;
        if (o_stall !== 1'b0) begin n_fail++; $display("FAIL load_use_release: got %b expected 0", o_stall); end
        step();
        n_tests++;
        if ({o_valid, o_op1, o_imm, o_tgt, o_wr_en} !== {1'b1, 16'h1234, 16'hFFFF, 3'd3, 1'b1}) begin
            n_fail++;
            $display("FAIL load_use_mem_fwd: got v=%b op1=%h imm=%h tgt=%0d we=%b expected v=1 op1=1234 imm=ffff tgt=3 we=1",
                     o_valid, o_op1, o_imm, o_tgt, o_wr_en);
        end
        set_idle();
    endtask

    task automatic test_priority();
        i_valid = 1; i_instr = enc_rrr(0, 1, 5, 0);
        i_rf_src1_data = 16'h1111; i_rf_src2_data = 16'h2222;
        i_mem_wr_en = 1; i_mem_tgt = 3'd5; i_mem_data = 16'hAAAA;
        i_wb_wr_en = 1; i_wb_tgt = 3'd5; i_wb_data = 16'hBBBB;
        step();
        n_tests++;
        if ({o_op1, o_op2} !== {16'hAAAA, 16'h0000}) begin
            n_fail++; $display("FAIL mem_over_wb: got op1=%h op2=%h expected aaaa/0000", o_op1, o_op2);
        end
        set_idle();
        i_valid = 1; i_instr = enc_rrr(0, 1, 0, 0);
        i_rf_src1_data = 16'h5555; i_rf_src2_data = 16'h5555;
        i_ex_valid = 1; i_ex_wr_en = 1; i_ex_tgt = 3'd0; i_ex_data = 16'h7777;
        i_mem_wr_en = 1; i_mem_tgt = 3'd0; i_mem_data = 16'h6666;
        step();
        n_tests++;
        if ({o_op1, o_op2} !== 32'h0) begin
            n_fail++; $display("FAIL r0_zero: got op1=%h op2=%h expected 0000/0000", o_op1, o_op2);
        end
        set_idle();
        i_valid = 1; i_instr = enc_rrr(2, 2, 6, 6);
        i_ex_valid = 1; i_ex_wr_en = 1; i_ex_tgt = 3'd6; i_ex_data = 16'h0E0E;
        i_mem_wr_en = 1; i_mem_tgt = 3'd6; i_mem_data = 16'h0A0A;
        i_wb_wr_en = 1; i_wb_tgt = 3'd3; i_wb_data = 16'hCCCC;
        step();
        n_tests++;
        if ({o_op1, o_op2, o_opcode} !== {16'h0E0E, 16'h0E0E, 3'd2}) begin
            n_fail++; $display("FAIL ex_over_mem: got op1=%h op2=%h opc=%0d expected 0e0e/0e0e/2", o_op1, o_op2, o_opcode);
        end
        i_instr = enc_rri(1, 2, 3, 1); i_ex_valid = 0; i_rf_src1_data = 16'h4321;
        step();
        n_tests++;
        if (o_op1 !== 16'hCCCC) begin
            n_fail++; $display("FAIL wb_bypass: got %h expected cccc", o_op1);
        end
        set_idle();
    endtask

    task automatic test_lui_sw();
        i_valid = 1; i_instr = enc_ri(3, 7, 10'h3FF);
        step();
        n_tests++;
        if ({o_imm, o_tgt, o_wr_en} !== {16'hFFC0, 3'd7, 1'b1}) begin
            n_fail++; $display("FAIL lui_decode: got imm=%h tgt=%0d we=%b expected ffc0/7/1", o_imm, o_tgt, o_wr_en);
        end
        i_instr = enc_rri(4, 1, 2, 3);
        #2;
        n_tests++;
        if ({o_rf_src1, o_rf_src2} !== {3'd2, 3'd1}) begin
            n_fail++; $display("FAIL sw_srcs: got %0d/%0d expected 2/1", o_rf_src1, o_rf_src2);
        end
        step();
        n_tests++;
        if ({o_wr_en, o_tgt, o_imm, o_valid} !== {1'b0, 3'd0, 16'h0003, 1'b1}) begin
            n_fail++; $display("FAIL sw_decode: got we=%b tgt=%0d imm=%h v=%b expected 0/0/0003/1", o_wr_en, o_tgt, o_imm, o_valid);
        end
        i_instr = enc_rri(7, 0, 4, 7'h55);
        step();
        n_tests++;
        if ({o_imm, o_wr_en, o_tgt} !== {16'h0000, 1'b0, 3'd0}) begin
            n_fail++; $display("FAIL jalr_r0: got imm=%h we=%b tgt=%0d expected 0000/0/0", o_imm, o_wr_en, o_tgt);
        end
        set_idle();
    endtask

    task automatic test_flush_hold();
        bundle_t exp;
        i_valid = 1; i_instr = enc_rri(6, 1, 2, 4); i_flush = 1;
        #2;
        n_tests++;
        if (o_stall !== 1'b0) begin n_fail++; $display("FAIL flush_stall: got %b expected 0", o_stall); end
        step();
        n_tests++;
        if (o_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %b expected 0", o_valid); end
        set_idle();
        i_valid = 1; i_instr = enc_rri(1, 2, 1, 5); i_pc = 16'h0123; i_rf_src1_data = 16'h1111;
        exp = '{v: 1'b1, op: 3'd1, tgt: 3'd2, we: 1'b1, ld: 1'b0, op1: 16'h1111, op2: 16'h0,
                imm: 16'h0005, pc: 16'h0123};
        step();
        for (int c = 0; c < 2; c++) begin
            i_hold = 1; i_instr = enc_rrr(2, 6, 3, 4); i_pc = 16'h0200 + 16'(c);
            i_rf_src1_data = 16'h7070; i_rf_src2_data = 16'h0707;
            i_ex_valid = 1; i_ex_wr_en = 1; i_ex_is_load = 1; i_ex_tgt = 3'd3;
            #2;
            n_tests++;
            if (o_stall !== 1'b1) begin n_fail++; $display("FAIL hold_stall[%0d]: got %b expected 1", c, o_stall); end
            step();
            n_tests++;
            if ({o_valid, o_opcode, o_tgt, o_wr_en, o_is_load, o_op1, o_op2, o_imm, o_pc} !== exp) begin
                n_fail++;
                $display("FAIL hold_retain[%0d]: got %h expected %h", c,
                         {o_valid, o_opcode, o_tgt, o_wr_en, o_is_load, o_op1, o_op2, o_imm, o_pc}, exp);
            end
        end
        i_hold = 1; i_flush = 1;
        #2;
        n_tests++;
        if (o_stall !== 1'b0) begin n_fail++; $display("FAIL hold_flush_stall: got %b expected 0", o_stall); end
        step();
        n_tests++;
        if (o_valid !== 1'b0) begin n_fail++; $display("FAIL hold_flush_valid: got %b expected 0", o_valid); end
        set_idle();
    endtask

    task automatic test_reset_mid();
        logic [75:0] all_out;
        i_valid = 1; i_instr = enc_rrr(0, 3, 1, 2); i_rf_src1_data = 16'h0101; i_pc = 16'h0042;
        step();
        n_tests++;
        if (o_valid !== 1'b1) begin n_fail++; $display("FAIL pre_reset_valid: got %b expected 1", o_valid); end
        #2;
        i_rst_n = 0;
        #1;
        all_out = {o_valid, o_opcode, o_tgt, o_wr_en, o_is_load, o_op1, o_op2, o_imm, o_pc};
        n_tests++;
        if (all_out !== '0) begin n_fail++; $display("FAIL async_reset: got %h expected 0", all_out); end
        @(negedge i_clk);
        i_rst_n = 1;
        i_instr = enc_ri(3, 1, 1); i_pc = 16'h0077;
        step();
        n_tests++;
        if ({o_valid, o_opcode, o_tgt, o_imm, o_pc} !== {1'b1, 3'd3, 3'd1, 16'h0040, 16'h0077}) begin
            n_fail++;
            $display("FAIL post_reset_capture: got v=%b opc=%0d tgt=%0d imm=%h pc=%h expected 1/3/1/0040/0077",
                     o_valid, o_opcode, o_tgt, o_imm, o_pc);
        end
        set_idle();
    endtask

    task automatic test_random();
        bundle_t exp;
        bit      kd, kw, kl, hz, exp_stall;
        set_idle();
        i_rst_n = 0;
        #2;
        i_rst_n = 1;
        exp = '0; kd = 1; kw = 1; kl = 1;
        for (int n = 0; n < 400; n++) begin
            i_valid = ($urandom_range(0, 9) < 8);
            i_instr = 16'($urandom); i_pc = 16'($urandom);
            i_flush = ($urandom_range(0, 9) == 0);
            i_hold  = ($urandom_range(0, 6) == 0);
            i_rf_src1_data = 16'($urandom); i_rf_src2_data = 16'($urandom);
            i_ex_valid = 1'($urandom); i_ex_wr_en = 1'($urandom);
            i_ex_is_load = ($urandom_range(0, 2) == 0);
            i_ex_tgt = 3'($urandom); i_ex_data = 16'($urandom);
            i_mem_wr_en = 1'($urandom); i_mem_tgt = 3'($urandom); i_mem_data = 16'($urandom);
            i_wb_wr_en = 1'($urandom); i_wb_tgt = 3'($urandom); i_wb_data = 16'($urandom);
            #2;
            hz = m_hazard();
            exp_stall = !i_flush && (i_hold || hz);
            n_tests++;
            if (o_stall !== exp_stall) begin
                n_fail++; $display("FAIL rnd_stall[%0d]: got %b expected %b", n, o_stall, exp_stall);
            end
            n_tests++;
            if ({o_rf_src1, o_rf_src2} !== {m_src1(), m_src2()}) begin
                n_fail++; $display("FAIL rnd_srcs[%0d]: got %0d/%0d expected %0d/%0d", n, o_rf_src1, o_rf_src2, m_src1(), m_src2());
            end
            if (i_flush) begin
                exp.v = 0; kd = 0; kw = 0; kl = 0;
            end else if (i_hold) begin
                kd = kd;
            end else if (hz) begin
                exp.v = 0; exp.we = 0; exp.ld = 0; kd = 0; kw = 1; kl = 1;
            end else begin
                exp = m_capture(); kd = 1; kw = 1; kl = exp.v;
            end
            step();
            n_tests++;
            if (o_valid !== exp.v) begin
                n_fail++; $display("FAIL rnd_valid[%0d]: got %b expected %b", n, o_valid, exp.v);
            end
            if (kw) begin
                n_tests++;
                if (o_wr_en !== exp.we) begin
                    n_fail++; $display("FAIL rnd_wr_en[%0d]: got %b expected %b", n, o_wr_en, exp.we);
                end
            end
            if (kl) begin
                n_tests++;
                if (o_is_load !== exp.ld) begin
                    n_fail++; $display("FAIL rnd_is_load[%0d]: got %b expected %b", n, o_is_load, exp.ld);
                end
            end
            if (kd) begin
                n_tests++;
                if ({o_opcode, o_tgt, o_op1, o_op2, o_imm, o_pc} !== {exp.op, exp.tgt, exp.op1, exp.op2, exp.imm, exp.pc}) begin
                    n_fail++;
                    $display("FAIL rnd_bundle[%0d]: got opc=%0d tgt=%0d op1=%h op2=%h imm=%h pc=%h expected opc=%0d tgt=%0d op1=%h op2=%h imm=%h pc=%h",
                             n, o_opcode, o_tgt, o_op1, o_op2, o_imm, o_pc,
                             exp.op, exp.tgt, exp.op1, exp.op2, exp.imm, exp.pc);
                end
            end
        end
        set_idle();
    endtask

    initial begin
        test_reset();
        test_ex_bypass();
        test_load_use();
        test_priority();
        test_lui_sw();
        test_flush_hold();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
